tie_ipq_consumer: RTL and testbench
===================================

// Module: tie_ipq_consumer
// PURPOSE
//  Consumer end of a TIE input-queue (IPQ) interface. Stands in for the popping Xtensa core when an
//  xtsc_queue/queue instance is co-simulated without core1. Pops a programmed number of 32-bit words
//  at a throttled rate and checks each word against an incrementing pattern. Reports counts, errors and done.
// PARAMETERS
//  DATA_W      32  queue word width (TIE_IPQ)
//  CNT_W       16  width of word/error counters and num_words
//  GAP_CYCLES  0   idle cycles inserted after every accepted pop (0 = pop back-to-back)
// PORTS
//  CLK             in   1       system clock, all logic on rising edge
//  BReset          in   1       asynchronous, active-high reset
//  start           in   1       1-cycle pulse: begin a run (ignored unless IDLE or DONE)
//  num_words       in   CNT_W   words to pop this run, sampled on start; 0 = immediate DONE
//  seed            in   DATA_W  expected value of first word, sampled on start
//  TIE_IPQ_PopReq  out  1       pop request to queue
//  TIE_IPQ         in   DATA_W  queue head data, valid whenever TIE_IPQ_Empty==0
//  TIE_IPQ_Empty   in   1       queue empty
//  busy            out  1       run in progress (RUN or GAP)
//  done            out  1       run complete, held until next start
//  word_count      out  CNT_W   words accepted this run
//  err_count       out  CNT_W   mismatching words this run, saturates at all-ones
//  first_err_idx   out  CNT_W   index of first mismatch; all-ones if none
//  last_data       out  DATA_W  most recently accepted word
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; PopReq=0, busy=0, done=0, word_count=0,
//    err_count=0, first_err_idx=all-ones, last_data=0, expected=0.
//  - Handshake: pop accepted in cycle where PopReq==1 && TIE_IPQ_Empty==0; data sampled that edge
//    (first-word-fall-through). PopReq with Empty==1 is a no-op, no word consumed, request stays up.
//  - PopReq is a registered output: 1 only in RUN; drops the cycle after the final accept.
//  - States: IDLE -start-> RUN (num_words!=0) or DONE (num_words==0, done 1 cycle after start).
//    RUN -accept, remaining>1, GAP_CYCLES>0-> GAP; -accept, remaining>1, GAP_CYCLES==0-> RUN;
//    -accept of last word-> DONE. GAP -gap counter reaches GAP_CYCLES-> RUN. DONE -start-> as IDLE.
//  - start in RUN/GAP ignored. start clears counters, first_err_idx, done on the same edge it is taken.
//  - Check: on accept, mismatch if TIE_IPQ != expected; expected increments mod 2^DATA_W per accept
//    (wraps ffffffff->0). First mismatch latches word_count (pre-increment) into first_err_idx.
//  - Counters: word_count increments per accept (cannot overflow, bounded by num_words);
//    err_count saturates.
//  - Throughput: GAP_CYCLES=0 and queue never empty -> one word per cycle.
//  - Reset mid-run: all state and outputs return to reset values immediately; no pop issued after.
// CONFIGURATION
//  TIE_IPQ_CONSUMER_CHECKSUM_EN defined: adds output checksum [DATA_W] = running sum mod 2^DATA_W
//    of accepted words; cleared by reset and start; updated on same edge as word_count.
//  Undefined: no checksum port, no adder; all other behaviour identical.
// TESTING
//  1 seed=100,num_words=4,queue preloaded 100..103 -> PopReq 4 cycles, done, word_count=4, err=0,
//    last_data=103, first_err_idx=ffff.
//  2 queue empty 5 cycles after start, then words arrive -> PopReq held high, no count change while
//    empty, run completes with correct count.
//  3 words 7,8,99,10 with seed=7 -> err_count=1, first_err_idx=2, word_count=4.
//  4 seed=fffffffe, words fffffffe,ffffffff,0 -> err_count=0 (wrap).
//  5 GAP_CYCLES=2, 3 words, full queue -> accepts on cycles 0,3,6 relative to first PopReq.
//  6 BReset asserted after 2 of 8 words -> outputs at reset values same cycle, PopReq=0; new start
//    runs cleanly. With CHECKSUM_EN: words 1,2,3 -> checksum=6.

Source files
------------

// File: rtl/tie_ipq_consumer.sv
// ---------------------------------------------------------------------------
// tie_ipq_consumer
//   Consumer end of a TIE input-queue (IPQ) interface. Takes the place of the
//   popping core when a queue model is co-simulated without it. On start it
//   pops num_words words at a throttled rate and checks each one against an
//   incrementing pattern that begins at seed. It reports the word count, the
//   error count, the index of the first error, the last word and a done flag.
//
//   Parameters
//     DATA_W      queue word width
//     CNT_W       width of num_words and of the word/error counters
//     GAP_CYCLES  idle cycles inserted after every accepted pop (0 = none)
//
//   Ports
//     CLK             clock, all logic on the rising edge
//     BReset          asynchronous active-high reset
//     start           1-cycle pulse, begins a run from IDLE or DONE
//     num_words       words to pop this run, sampled on start (0 = done at once)
//     seed            expected value of the first word, sampled on start
//     TIE_IPQ_PopReq  registered pop request to the queue
//     TIE_IPQ         queue head data, valid while TIE_IPQ_Empty is low
//     TIE_IPQ_Empty   queue empty
//     busy            run in progress (RUN or GAP)
//     done            run complete, held until the next start
//     word_count      words accepted this run
//     err_count       mismatching words this run, saturating
//     first_err_idx   index of the first mismatch, all-ones if none
//     last_data       most recently accepted word
//     checksum        running sum of accepted words (only with the macro below)
//
//   Build option
//     TIE_IPQ_CONSUMER_CHECKSUM_EN  adds the checksum output and its adder.
// ---------------------------------------------------------------------------
module tie_ipq_consumer #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              BReset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] seed,
    output logic              TIE_IPQ_PopReq,
    input  logic [DATA_W-1:0] TIE_IPQ,
    input  logic              TIE_IPQ_Empty,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] last_data
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // Gap counter runs 0 .. GAP_CYCLES-1 while in GAP.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              pop_req_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic [DATA_W-1:0] expected_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [CNT_W-1:0]  word_count_reg;
    logic [CNT_W-1:0]  err_count_reg;
    logic [CNT_W-1:0]  first_err_reg;
    logic [DATA_W-1:0] last_data_reg;

    logic accept;
    logic start_take;
    logic mismatch;
    logic gap_last;

    // pop_req_reg is high exactly when state_reg is RUN, so accept can only
    // occur in RUN and can never coincide with a taken start.
    assign accept     = pop_req_reg & ~TIE_IPQ_Empty;
    assign start_take = start & ((state_reg == IDLE) | (state_reg == DONE));
    assign mismatch   = accept & (TIE_IPQ != expected_reg);
    assign gap_last   = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            state_reg      <= IDLE;
            pop_req_reg    <= 1'b0;
            remaining_reg  <= '0;
            expected_reg   <= '0;
            gap_cnt_reg    <= '0;
            word_count_reg <= '0;
            err_count_reg  <= '0;
            first_err_reg  <= '1;
            last_data_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            // Registered request: rises the cycle RUN is entered and drops
            // the cycle after the final accept.
            pop_req_reg <= (state_next == RUN);

            // Cleared everywhere outside GAP so every gap starts from zero.
            if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end else begin
                gap_cnt_reg <= '0;
            end

            if (start_take) begin
                remaining_reg  <= num_words;
                expected_reg   <= seed;
                word_count_reg <= '0;
                err_count_reg  <= '0;
                first_err_reg  <= '1;
            end else if (accept) begin
                remaining_reg  <= remaining_reg - CNT_W'(1);
                expected_reg   <= expected_reg + DATA_W'(1);
                word_count_reg <= word_count_reg + CNT_W'(1);
                last_data_reg  <= TIE_IPQ;
                if (mismatch) begin
                    if (err_count_reg != '1) begin
                        err_count_reg <= err_count_reg + CNT_W'(1);
                    end
                    // err_count is still zero only before the first mismatch.
                    if (err_count_reg == '0) begin
                        first_err_reg <= word_count_reg;
                    end
                end
            end
        end
    end

`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            checksum_reg <= '0;
        end else if (start_take) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + TIE_IPQ;
        end
    end

    assign checksum = checksum_reg;
`endif

    assign TIE_IPQ_PopReq = pop_req_reg;
    assign busy           = (state_reg == RUN) | (state_reg == GAP);
    assign done           = (state_reg == DONE);
    assign word_count     = word_count_reg;
    assign err_count      = err_count_reg;
    assign first_err_idx  = first_err_reg;
    assign last_data      = last_data_reg;

endmodule

// File: tb/tb_tie_ipq_consumer.sv
// ---------------------------------------------------------------------------
// tb_tie_ipq_consumer
//   Two consumers share one queue model: dut_a pops back-to-back, dut_b waits
//   two idle cycles after each pop. Only the selected consumer's requests
//   drain the queue. Run results are predicted from the word list and pushed
//   into a scoreboard when a run is issued; a monitor compares every accepted
//   word and every completed run against those predictions.
// ---------------------------------------------------------------------------
module tb_tie_ipq_consumer;

    logic        CLK = 1'b0;
    logic        BReset;
    logic        start_a, start_b;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic [31:0] head;
    logic        empty;

    logic        pop_a, busy_a, done_a;
    logic [15:0] wc_a, ec_a, fe_a;
    logic [31:0] ld_a;
    logic        pop_b, busy_b, done_b;
    logic [15:0] wc_b, ec_b, fe_b;
    logic [31:0] ld_b;
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
    logic [31:0] ck_a, ck_b;
`endif

    tie_ipq_consumer #(.DATA_W(32), .CNT_W(16), .GAP_CYCLES(0)) dut_a (
        .CLK(CLK), .BReset(BReset), .start(start_a), .num_words(num_words), .seed(seed),
        .TIE_IPQ_PopReq(pop_a), .TIE_IPQ(head), .TIE_IPQ_Empty(empty),
        .busy(busy_a), .done(done_a), .word_count(wc_a), .err_count(ec_a),
        .first_err_idx(fe_a), .last_data(ld_a)
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
        , .checksum(ck_a)
`endif
    );

    tie_ipq_consumer #(.DATA_W(32), .CNT_W(16), .GAP_CYCLES(2)) dut_b (
        .CLK(CLK), .BReset(BReset), .start(start_b), .num_words(num_words), .seed(seed),
        .TIE_IPQ_PopReq(pop_b), .TIE_IPQ(head), .TIE_IPQ_Empty(empty),
        .busy(busy_b), .done(done_b), .word_count(wc_b), .err_count(ec_b),
        .first_err_idx(fe_b), .last_data(ld_b)
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
        , .checksum(ck_b)
`endif
    );

    initial forever #5 CLK = ~CLK;

    // Selected consumer view
    logic        sel;
    logic        pop_s, busy_s, done_s;
    logic [15:0] wc_s, ec_s, fe_s;
    logic [31:0] ld_s;
    assign pop_s  = sel ? pop_b  : pop_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign wc_s   = sel ? wc_b   : wc_a;
    assign ec_s   = sel ? ec_b   : ec_a;
    assign fe_s   = sel ? fe_b   : fe_a;
    assign ld_s   = sel ? ld_b   : ld_a;
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
    logic [31:0] ck_s;
    assign ck_s = sel ? ck_b : ck_a;
`endif

    typedef struct {
        logic [15:0] wc;
        logic [15:0] ec;
        logic [15:0] fe;
        logic [31:0] ld;
        logic [31:0] sum;
    } res_t;

    logic [31:0] wq[$];         // queue contents, head at index 0
    res_t        exp_q[$];      // predicted run results
    int          acc_cyc[$];    // cycle number of every accepted pop
    logic [31:0] run_words[$];  // words of the run being issued
    logic [31:0] model_last[2];
    bit          hold_empty;
    bit          pend;
    bit          acc_at_edge;
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          run_base;
    int          run_start_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle counter and handshake capture at the active edge.
    initial begin
        cyc = 0;
        acc_at_edge = 1'b0;
        forever begin
            @(posedge CLK);
            cyc++;
            acc_at_edge = pend && !BReset;
        end
    end

    // Monitor: drains the queue model, checks every accepted word and every
    // completed run, then re-presents the queue head for the next edge.
    initial begin
        int          ref_cnt;
        logic [31:0] w;
        res_t        r;
        bit          dpa, dpb, rise;
        ref_cnt = 0; dpa = 0; dpb = 0; pend = 0;
        empty = 1'b1; head = '0;
        forever begin
            @(negedge CLK);
            if (BReset) begin
                ref_cnt = 0;
            end else if (acc_at_edge) begin
                w = wq.pop_front();
                ref_cnt++;
                acc_cyc.push_back(cyc);
                $display("[%0t] pop dut=%0d idx=%0d data=%h", $time, sel, ref_cnt - 1, w);
                chk("last_data", ld_s, w);
                chk("word_count", 32'(wc_s), 32'(ref_cnt));
            end
            rise = sel ? (done_b && !dpb) : (done_a && !dpa);
            if (rise && !BReset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    $display("[%0t] run done dut=%0d words=%0d errs=%0d first=%h last=%h",
                             $time, sel, wc_s, ec_s, fe_s, ld_s);
                    chk("run_word_count", 32'(wc_s), 32'(r.wc));
                    chk("run_err_count", 32'(ec_s), 32'(r.ec));
                    chk("run_first_err_idx", 32'(fe_s), 32'(r.fe));
                    chk("run_last_data", ld_s, r.ld);
                    chk("run_busy_low", 32'(busy_s), 32'd0);
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
                    chk("run_checksum", ck_s, r.sum);
`endif
                end
            end
            dpa = done_a;
            dpb = done_b;
            #1;
            if (((start_a && !sel) || (start_b && sel)) && !busy_s) ref_cnt = 0;
            empty = hold_empty || (wq.size() == 0);
            head  = (wq.size() != 0) ? wq[0] : 32'h0;
            pend  = pop_s && !empty;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_popreq_a"}, 32'(pop_a), 32'd0);
        chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        chk({tag, "_done_a"}, 32'(done_a), 32'd0);
        chk({tag, "_word_count"}, 32'(wc_a), 32'd0);
        chk({tag, "_err_count"}, 32'(ec_a), 32'd0);
        chk({tag, "_first_err_idx"}, 32'(fe_a), 32'h0000ffff);
        chk({tag, "_last_data"}, ld_a, 32'd0);
        chk({tag, "_popreq_b"}, 32'(pop_b), 32'd0);
        chk({tag, "_done_b"}, 32'(done_b), 32'd0);
`ifdef TIE_IPQ_CONSUMER_CHECKSUM_EN
        chk({tag, "_checksum"}, ck_a, 32'd0);
`endif
    endtask

    // Issue the words in run_words to one consumer. late>0 holds the queue
    // empty for that many cycles after start; rnd_empty starves it randomly.
    task automatic do_run(input bit use_b, input logic [31:0] s, input bit rnd_empty, input int late);
        res_t e;
        int   n;
        bit   fin;
        n = run_words.size();
        e.wc = 16'(n); e.ec = 0; e.fe = 16'hffff; e.ld = model_last[use_b]; e.sum = 0;
        foreach (run_words[i]) begin
            if (run_words[i] != s + 32'(i)) begin
                if (e.fe == 16'hffff) e.fe = 16'(i);
                e.ec++;
            end
            e.ld  = run_words[i];
            e.sum = e.sum + run_words[i];
        end
        model_last[use_b] = e.ld;
        exp_q.push_back(e);
        sel = use_b; seed = s; num_words = 16'(n);
        if (late == 0) foreach (run_words[i]) wq.push_back(run_words[i]);
        run_base = acc_cyc.size();
        run_start_cyc = cyc;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0; start_b = 1'b0;
        fin = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (late > 0 && k < late) begin
                chk("popreq_held_while_empty", 32'(pop_s), 32'd1);
                chk("no_count_while_empty", 32'(wc_s), 32'd0);
            end
            if (late > 0 && k == late) foreach (run_words[i]) wq.push_back(run_words[i]);
            if (rnd_empty) hold_empty = ($urandom_range(0, 3) == 0);
            if (done_s) fin = 1;
            else @(negedge CLK);
        end
        hold_empty = 0;
        if (!fin) chk("run_timeout", 32'd1, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        run_words.delete();
    endtask

    initial begin
        logic [31:0] s, w;
        int          n;
        bit          hit;
        BReset = 1'b1; start_a = 0; start_b = 0; num_words = 0; seed = 0;
        sel = 0; hold_empty = 0; model_last[0] = 0; model_last[1] = 0;
        repeat (3) @(negedge CLK);
        chk_reset("por");
        BReset = 1'b0;
        @(negedge CLK);

        // num_words==0: done one cycle after start, nothing popped
        do_run(0, 32'h5, 0, 0);

        // Full queue, seed 100: one accept per cycle starting at the first PopReq
        for (int i = 0; i < 4; i++) run_words.push_back(32'd100 + 32'(i));
        do_run(0, 32'd100, 0, 0);
        chk("t1_accepts", 32'(acc_cyc.size() - run_base), 32'd4);
        if (acc_cyc.size() == run_base + 4) begin
            chk("t1_first_accept_cycle", 32'(acc_cyc[run_base]), 32'(run_start_cyc + 2));
            for (int i = 1; i < 4; i++)
                chk("t1_back_to_back", 32'(acc_cyc[run_base + i] - acc_cyc[run_base + i - 1]), 32'd1);
        end
        chk("t1_popreq_dropped", 32'(pop_a), 32'd0);

        // Queue empty for five cycles after start
        for (int i = 0; i < 6; i++) run_words.push_back(32'h20 + 32'(i));
        do_run(0, 32'h20, 0, 5);

        // One bad word at index 2
        run_words = '{32'd7, 32'd8, 32'd99, 32'd10};
        do_run(0, 32'd7, 0, 0);

        // Expected value wraps through zero
        run_words = '{32'hfffffffe, 32'hffffffff, 32'h0};
        do_run(0, 32'hfffffffe, 0, 0);

        // Two idle cycles after every pop
        run_words = '{32'd50, 32'd51, 32'd52};
        do_run(1, 32'd50, 0, 0);
        chk("t5_accepts", 32'(acc_cyc.size() - run_base), 32'd3);
        if (acc_cyc.size() == run_base + 3) begin
            chk("t5_first_accept_cycle", 32'(acc_cyc[run_base]), 32'(run_start_cyc + 2));
            chk("t5_gap1", 32'(acc_cyc[run_base + 1] - acc_cyc[run_base]), 32'd3);
            chk("t5_gap2", 32'(acc_cyc[run_base + 2] - acc_cyc[run_base + 1]), 32'd3);
        end

        // Reset after two of eight words
        sel = 0; seed = 32'h1000; num_words = 16'd8;
        for (int i = 0; i < 8; i++) wq.push_back(32'h1000 + 32'(i));
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (wc_a == 16'd2) hit = 1;
            else @(negedge CLK);
        end
        chk("t6_reached_two_words", 32'(hit), 32'd1);
        BReset = 1'b1;
        #2;
        chk_reset("midrun");
        wq.delete();
        @(negedge CLK);
        chk("t6_no_pop_in_reset", 32'(pop_a), 32'd0);
        BReset = 1'b0;
        model_last[0] = 0; model_last[1] = 0;
        @(negedge CLK);
        chk("t6_no_pop_after_reset", 32'(pop_a), 32'd0);
        run_words = '{32'd1, 32'd2, 32'd3};
        do_run(0, 32'd1, 0, 0);

        // Randomized runs with random starvation and occasional bad words
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 20);
            if ($urandom_range(0, 2) == 0) s = 32'hffffffff - 32'($urandom_range(0, 10));
            else s = $urandom;
            for (int i = 0; i < n; i++) begin
                w = s + 32'(i);
                if ($urandom_range(0, 5) == 0) w = w ^ 32'($urandom_range(1, 255));
                run_words.push_back(w);
            end
            do_run(($urandom_range(0, 3) == 0), s, 1, 0);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("queue_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
